digi_scan_driver: RTL and testbench
===================================

DIGI_SCAN_DRIVER -- requirements
Module: digi_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: iClk cycles per digit slot; legal range is 2 or more.
REQ-002 SHALL have parameter BLANK_LZ, default 1: 1 enables leading-zero blanking, 0 disables it.
REQ-003 SHALL have port iClk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port iRst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port iValue, input, 16 bits: four hex digits; digit n = iValue[4n+3:4n].
REQ-006 SHALL have port iLoad, input, 1 bit: 1-cycle strobe that captures iValue and iDpMask.
REQ-007 SHALL have port iDpMask, input, 4 bits: per-digit decimal point; bit n=1 lights dp of digit n.
REQ-008 SHALL have port iEnable, input, 1 bit: 0 blanks the display.
REQ-009 SHALL have port oDigi, output, 12 bits: [11:8] anodes for digits 3..0, active-low, one-hot-low; [7:0] segments {dp,g,f,e,d,c,b,a}, active-low.
REQ-010 SHALL have port oFrame, output, 1 bit: 1-cycle pulse at each frame boundary.

Function
REQ-011 SHALL run a divider counter 0..SCAN_DIV-1 that wraps to 0. Tick = counter at SCAN_DIV-1.
REQ-012 SHALL advance digit index 0->1->2->3->0 on each tick. Frame boundary = tick while index=3.
REQ-013 SHALL keep a display register (value+dp) and a pending register with a pending_valid flag.
REQ-014 On iLoad without a frame boundary: pending <= {iValue,iDpMask}; pending_valid <= 1; the display does not change.
REQ-015 On a frame boundary without iLoad and pending_valid=1: display <= pending; pending_valid <= 0.
REQ-016 On iLoad in the frame-boundary cycle: display <= {iValue,iDpMask} directly; pending_valid <= 0; older pending data is discarded.
REQ-017 Repeated iLoad before a boundary: the last one wins; no tearing within a frame.
REQ-018 oFrame SHALL be 1 in the cycle after each frame-boundary tick, otherwise 0.
REQ-019 oDigi SHALL be registered from the current index and display, so it reflects an index change one cycle later.
REQ-020 Anodes: the digit at current index has its anode=0 and all others=1.
REQ-021 Segment encoding for [6:0], hex 0-F: C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E.
REQ-022 dp bit [7] = ~dp_mask[index].
REQ-023 Leading-zero blanking applies when BLANK_LZ=1:
  - digit3 is blank if value[15:12]=0
  - digit2 is blank if value[15:8]=0
  - digit1 is blank if value[15:4]=0
  - digit0 is never blank
REQ-024 A blanked digit SHALL drive segments [6:0]=7F, keep its anode active, and still honour dp.
REQ-025 iEnable=0 SHALL force oDigi=FFF on the next cycle. Counter, index and load logic keep running.
REQ-026 iEnable 0->1 SHALL resume output at the current index with no counter reset.

Reset
REQ-027 iRst=1 at a clock edge SHALL set:
  - counter=0 and index=0
  - display and pending to 0; pending_valid=0
  - oDigi=FFF and oFrame=0
REQ-028 iRst SHALL override iLoad in the same cycle; the load is lost.
REQ-029 Reset mid-frame SHALL discard pending data.
REQ-030 First cycle after reset release (iEnable=1, BLANK_LZ=1): oDigi=EC0, digit0 showing "0".

Verification
REQ-031 SCAN_DIV=4, reset release, iEnable=1 -> oDigi=EC0; anodes go E,D,B,7,E at 4-cycle spacing; oFrame pulses every 16 cycles.
REQ-032 iLoad iValue=1234, iDpMask=0100 mid-frame -> display unchanged until the boundary. Next frame shows:
  - digit0: E99 ("4")
  - digit1: DB0 ("3")
  - digit2: B24 ("2" with dp, bit7=0)
  - digit3: 7F9 ("1")
REQ-033 iValue=0005, BLANK_LZ=1 -> digit0 E92; digit1 DFF; digit2 BFF; digit3 7FF.
REQ-034 iLoad coincident with a frame-boundary tick, with an older pending value present -> the new value is shown in the immediately following frame; the older pending value never appears.
REQ-035 iEnable=0 for 10 cycles -> oDigi=FFF throughout. After re-enable, the anode pattern matches where the index would be with no interruption.
REQ-036 iRst asserted together with iLoad mid-scan -> oDigi=FFF and oFrame=0 the next cycle. After release, oDigi=EC0 and the load is not applied.

Source files
------------

// File: rtl/digi_scan_driver.sv
// Four-digit multiplexed 7-segment scan driver. Loads take effect only at frame
// boundaries so a frame never shows a mix of old and new digits.
module digi_scan_driver #(
    parameter int unsigned SCAN_DIV = 50000,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic [15:0] iValue,
    input  logic        iLoad,
    input  logic [3:0]  iDpMask,
    input  logic        iEnable,
    output logic [11:0] oDigi,
    output logic        oFrame
);

    localparam int unsigned CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CntMax = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [19:0]   disp_q, disp_d;  // {value, dp_mask}
    logic [19:0]   pend_q, pend_d;
    logic          pend_valid_q, pend_valid_d;
    logic [11:0]   digi_q, digi_d;
    logic          frame_q, frame_d;

    logic          tick;
    logic          boundary;
    logic [15:0]   cur_val;
    logic [3:0]    cur_dp;
    logic [3:0]    nibble;
    logic          blank;
    logic [6:0]    seg;
    logic [3:0]    anode;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        logic [7:0] s;
        case (h)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s[6:0];
    endfunction

    always_comb begin
        tick     = (cnt_q == CntMax);
        boundary = tick && (idx_q == 2'd3);
        cnt_d    = tick ? '0 : cnt_q + CW'(1);
        idx_d    = tick ? idx_q + 2'd1 : idx_q;
        frame_d  = boundary;

        disp_d       = disp_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        if (iLoad && boundary) begin
            // A load landing on the boundary supersedes anything still pending.
            disp_d       = {iValue, iDpMask};
            pend_valid_d = 1'b0;
        end else if (iLoad) begin
            pend_d       = {iValue, iDpMask};
            pend_valid_d = 1'b1;
        end else if (boundary && pend_valid_q) begin
            disp_d       = pend_q;
            pend_valid_d = 1'b0;
        end
    end

    always_comb begin
        cur_val = disp_q[19:4];
        cur_dp  = disp_q[3:0];
        nibble  = '0;
        blank   = 1'b0;
        case (idx_q)
            2'd0: begin
                nibble = cur_val[3:0];
                blank  = 1'b0;
            end
            2'd1: begin
                nibble = cur_val[7:4];
                blank  = (cur_val[15:4] == 12'h000);
            end
            2'd2: begin
                nibble = cur_val[11:8];
                blank  = (cur_val[15:8] == 8'h00);
            end
            default: begin
                nibble = cur_val[15:12];
                blank  = (cur_val[15:12] == 4'h0);
            end
        endcase
        seg    = (BLANK_LZ && blank) ? 7'h7F : hex7(nibble);
        anode  = ~(4'b0001 << idx_q);
        digi_d = iEnable ? {anode, ~cur_dp[idx_q], seg} : 12'hFFF;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            disp_q       <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            digi_q       <= 12'hFFF;
            frame_q      <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            digi_q       <= digi_d;
            frame_q      <= frame_d;
        end
    end

    assign oDigi  = digi_q;
    assign oFrame = frame_q;

endmodule

// File: tb/tb_digi_scan_driver.sv
// Directed bench for digi_scan_driver with SCAN_DIV=4: after reset release, edge k
// shows the digit at index ((k-1)/4)%4 and oFrame is high after edges 16, 32, ...
module tb_digi_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic        load;
    logic [3:0]  dp_mask;
    logic        enable;
    logic [11:0] digi;
    logic        frame;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    digi_scan_driver #(
        .SCAN_DIV(4),
        .BLANK_LZ(1'b1)
    ) dut (
        .iClk   (clk),
        .iRst   (rst),
        .iValue (value),
        .iLoad  (load),
        .iDpMask(dp_mask),
        .iEnable(enable),
        .oDigi  (digi),
        .oFrame (frame)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic chk_digi(input string tag, input logic [11:0] exp);
        checks++;
        assert (digi === exp)
        else begin
            errors++;
            $error("FAIL %s: oDigi observed=%h expected=%h (cyc %0d)", tag, digi, exp, cyc);
        end
    endtask

    task automatic chk_frame(input string tag, input logic exp);
        checks++;
        assert (frame === exp)
        else begin
            errors++;
            $error("FAIL %s: oFrame observed=%b expected=%b (cyc %0d)", tag, frame, exp, cyc);
        end
    endtask

    initial begin
        rst     = 1'b1;
        load    = 1'b0;
        value   = 16'h0000;
        dp_mask = 4'h0;
        enable  = 1'b1;
        step(2);
        chk_digi("reset_digi", 12'hFFF);
        chk_frame("reset_frame", 1'b0);

        // Scan of the all-zero display: only digit0 is unblanked.
        rst = 1'b0;
        cyc = 0;
        step(1);  chk_digi("first_after_reset", 12'hEC0);
        chk_frame("frame_low_c1", 1'b0);
        step(4);  chk_digi("zero_d1", 12'hDFF);
        step(4);  chk_digi("zero_d2", 12'hBFF);

        // Mid-frame load must wait for the frame boundary.
        value = 16'h1234; dp_mask = 4'b0100; load = 1'b1;
        step(1);  load = 1'b0;
        chk_digi("load_wait_d2", 12'hBFF);
        step(3);  chk_digi("load_wait_d3", 12'h7FF);
        chk_frame("frame_low_c13", 1'b0);
        step(2);  chk_frame("frame_low_c15", 1'b0);
        step(1);  chk_frame("frame_c16", 1'b1);
        step(1);  chk_frame("frame_low_c17", 1'b0);
        chk_digi("v1234_d0", 12'hE99);
        step(4);  chk_digi("v1234_d1", 12'hDB0);
        step(4);  chk_digi("v1234_d2_dp", 12'hB24);
        step(4);  chk_digi("v1234_d3", 12'h7F9);

        // Older pending value at edge 30, new load coincident with boundary edge 32.
        value = 16'h0005; dp_mask = 4'h0; load = 1'b1;
        step(1);  load = 1'b0;
        step(1);
        value = 16'hABCD; dp_mask = 4'b0001; load = 1'b1;
        step(1);  load = 1'b0;
        chk_frame("frame_c32", 1'b1);
        step(1);  chk_digi("vABCD_d0_dp", 12'hE21);
        step(4);  chk_digi("vABCD_d1", 12'hDC6);
        step(4);  chk_digi("vABCD_d2", 12'hB83);
        step(4);  chk_digi("vABCD_d3", 12'h788);
        step(4);  chk_digi("old_pending_dropped", 12'hE21);

        // Back-to-back loads: the last one wins.
        value = 16'h0099; dp_mask = 4'hF; load = 1'b1;
        step(1);
        value = 16'h0005; dp_mask = 4'h0;
        step(1);  load = 1'b0;
        step(14); chk_digi("v0005_d0", 12'hE92);
        step(4);  chk_digi("v0005_d1_blank", 12'hDFF);
        step(4);  chk_digi("v0005_d2_blank", 12'hBFF);
        step(4);  chk_digi("v0005_d3_blank", 12'h7FF);

        // Disable for 10 cycles; scan keeps running underneath.
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk_digi("disabled", 12'hFFF);
        end
        enable = 1'b1;
        step(1);  chk_digi("reenable_d1", 12'hDFF);
        step(1);  chk_digi("reenable_d2", 12'hBFF);

        // Pending load, then reset together with another load.
        value = 16'h0777; dp_mask = 4'h0; load = 1'b1;
        step(1);
        value = 16'h1234; rst = 1'b1;
        step(1);
        chk_digi("rst_load_digi", 12'hFFF);
        chk_frame("rst_load_frame", 1'b0);
        rst = 1'b0; load = 1'b0;
        cyc = 0;
        step(1);  chk_digi("post_rst_d0", 12'hEC0);
        step(4);  chk_digi("post_rst_d1", 12'hDFF);
        step(11); chk_frame("post_rst_frame", 1'b1);
        step(1);  chk_digi("post_rst_no_load", 12'hEC0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
